// File: rtl/vector_multiply.sv
// -----------------------------------------------------------------------------
// vector_multiply
//
// Element-wise signed fixed-point multiply, delta = error (a) * f'(z) (b).
// Operands are captured independently over valid/ready handshakes. TILING
// multipliers then process TILING elements per cycle, each raw product being
// arithmetically shifted right by FRACTION_WIDTH and saturated to the result
// cell width. The finished vector is held until the consumer accepts it.
// The error flag is sticky for the vector being computed: it is set if any
// element saturates.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous, active-low reset
//   a/a_valid     error vector in, element k at [k*A_CELL_WIDTH +: A_CELL_WIDTH]
//   a_ready       high while no a operand is held
//   b/b_valid     derivative vector in, packed the same way
//   b_ready       high while no b operand is held
//   result        product vector, packed the same way
//   result_valid  result is complete and stable
//   result_ready  consumer takes result
//   error         sticky saturation flag for the current vector
// -----------------------------------------------------------------------------
module vector_multiply #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING            = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
  input  logic                                   a_valid,
  output logic                                   a_ready,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
  input  logic                                   b_valid,
  output logic                                   b_ready,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                   result_valid,
  input  logic                                   result_ready,
  output logic                                   error
);

  localparam int PROD_W = A_CELL_WIDTH + B_CELL_WIDTH;
  // Counter can reach VECTOR_LEN-1+TILING after the last step; size it so it
  // never wraps.
  localparam int CNT_W  = $clog2(VECTOR_LEN + TILING + 1);

  localparam logic signed [PROD_W-1:0] SAT_MAX =
    PROD_W'((64'sd1 <<< (RESULT_CELL_WIDTH - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    PROD_W'(-(64'sd1 <<< (RESULT_CELL_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                                 state_q, state_d;
  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a_buf;
  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b_buf;
  logic                                   a_set, b_set;
  logic [CNT_W-1:0]                       counter;
  logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result_buf, result_next;
  logic                                   error_q, error_next;

  // Per-lane results gathered for the merge below.
  logic                         lane_valid [TILING];
  logic [CNT_W-1:0]             lane_idx   [TILING];
  logic [RESULT_CELL_WIDTH-1:0] lane_val   [TILING];
  logic                         lane_sat   [TILING];

  // Ready and valid come straight from registers, never from inputs.
  assign a_ready      = !a_set;
  assign b_ready      = !b_set;
  assign result_valid = (state_q == DONE);
  assign result       = result_buf;
  assign error        = error_q;

  for (genvar i = 0; i < TILING; i++) begin : g_lane
    logic [CNT_W-1:0]           k;
    logic [CNT_W-1:0]           idx;
    logic                       in_range;
    logic signed [A_CELL_WIDTH-1:0] ea;
    logic signed [B_CELL_WIDTH-1:0] eb;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   shifted;
    logic [RESULT_CELL_WIDTH-1:0] val;
    logic                       sat;

    assign k        = counter + CNT_W'(i);
    assign in_range = (k < CNT_W'(VECTOR_LEN));
    // Phantom lanes past the end read element 0 so no out-of-range select
    // ever produces X; their output is discarded by lane_valid.
    assign idx      = in_range ? k : '0;
    assign ea       = a_buf[idx*A_CELL_WIDTH +: A_CELL_WIDTH];
    assign eb       = b_buf[idx*B_CELL_WIDTH +: B_CELL_WIDTH];
    assign prod     = PROD_W'(ea) * PROD_W'(eb);
    // Arithmetic shift: rescale with truncation toward minus infinity.
    assign shifted  = prod >>> FRACTION_WIDTH;

    always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      val = shifted[RESULT_CELL_WIDTH-1:0];
      sat = 1'b0;
      if (shifted > SAT_MAX) begin
        val = SAT_MAX[RESULT_CELL_WIDTH-1:0];
        sat = 1'b1;
      end else if (shifted < SAT_MIN) begin
        val = SAT_MIN[RESULT_CELL_WIDTH-1:0];
        sat = 1'b1;
      end
    end

    assign lane_valid[i] = in_range;
    assign lane_idx[i]   = idx;
    assign lane_val[i]   = val;
    assign lane_sat[i]   = sat;
  end

  // Merge this cycle's lane outputs into the result buffer and error flag.
  always_comb begin
    result_next = result_buf;
    error_next  = error_q;
    for (int i = 0; i < TILING; i++) begin
      if (lane_valid[i]) begin
        result_next[lane_idx[i]*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = lane_val[i];
        error_next = error_next | lane_sat[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_set && b_set) state_d = CALC;
      CALC:    if (counter >= CNT_W'(VECTOR_LEN - TILING)) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: operand and result buffers are reset as well, so result reads
      // zero after reset and no stale operand can leak into a later vector.
      state_q    <= IDLE;
      a_buf      <= '0;
      b_buf      <= '0;
      a_set      <= 1'b0;
      b_set      <= 1'b0;
      counter    <= '0;
      result_buf <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (a_valid && !a_set) begin
            a_buf <= a;
            a_set <= 1'b1;
          end
          if (b_valid && !b_set) begin
            b_buf <= b;
            b_set <= 1'b1;
          end
          // Start of a new vector: clear the previous result and error.
          if (a_set && b_set) begin
            counter    <= '0;
            result_buf <= '0;
            error_q    <= 1'b0;
          end
        end
        CALC: begin
          counter    <= counter + CNT_W'(TILING);
          result_buf <= result_next;
          error_q    <= error_next;
        end
        DONE: begin
          if (result_ready) begin
            a_set <= 1'b0;
            b_set <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
